// File: rtl/sipo_receiver.sv
// Serial-in parallel-out receiver: assembles WIDTH-bit words MSB first while frame_n is high.
// Optional even-parity trailer bit when PARITY_CHECK_EN is defined (default build: no parity, parity_err tied low).
//
// state | meaning
// IDLE  | frame_n was low on the last edge; counter cleared, shift register holding
// SHIFT | frame_n was high on the last edge; a word (or parity bit) is being sampled
module sipo_receiver #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             frame_n,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             abort,
  output logic             parity_err
);

`ifdef PARITY_CHECK_EN
  localparam int LAST_IDX = WIDTH;
`else
  localparam int LAST_IDX = WIDTH - 1;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_IDX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [WIDTH-1:0] data_out_nxt;
  logic             valid_nxt, abort_nxt, perr_nxt;
  logic             last_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      abort      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shift_reg  <= shift_nxt;
      data_out   <= data_out_nxt;
      data_valid <= valid_nxt;
      abort      <= abort_nxt;
      parity_err <= perr_nxt;
    end
  end

  assign last_bit = (cnt == CNT_LAST);

  always_comb begin
    state_nxt    = frame_n ? SHIFT : IDLE;
    cnt_nxt      = cnt;
    shift_nxt    = shift_reg;
    data_out_nxt = data_out;
    valid_nxt    = 1'b0;
    abort_nxt    = 1'b0;
    perr_nxt     = parity_err;

    if (frame_n) begin
      if (last_bit) begin
        cnt_nxt   = '0;
        valid_nxt = 1'b1;
`ifdef PARITY_CHECK_EN
        // the shift register already holds the full word; this edge carries the parity bit
        data_out_nxt = shift_reg;
        perr_nxt     = (^shift_reg) ^ data_in;
`else
        shift_nxt    = {shift_reg[WIDTH-2:0], data_in};
        data_out_nxt = {shift_reg[WIDTH-2:0], data_in};
`endif
      end else begin
        cnt_nxt   = cnt + CNT_ONE;
        shift_nxt = {shift_reg[WIDTH-2:0], data_in};
      end
    end else begin
      cnt_nxt   = '0;
      abort_nxt = (state == SHIFT) && (cnt != '0);
    end

`ifndef PARITY_CHECK_EN
    perr_nxt = 1'b0;
`endif
  end

endmodule
